oht_bitmap_decoder: RTL

Index-to-one-hot decoder and occupancy bitmap; the write-side counterpart of the 1024-entry multi-detect priority encoder. Accepts binary set/clear index commands, decodes them to one-hot masks, and maintains a registered N-bit occupancy vector. That vector feeds the priority encoder's `oht` input directly. Also keeps an incremental population count, full/empty flags, and per-operation duplicate/miss detection, which mirrors the encoder's multi-detect.

---
 rtl/oht_bitmap_decoder_pkg.sv | 11 +
 rtl/oht_bitmap_decoder_bin_to_oht_decoder.sv | 23 ++
 rtl/oht_bitmap_decoder.sv | 115 +++++++++++
 3 files changed

// File: rtl/oht_bitmap_decoder_pkg.sv
// Shared constants and types for the occupancy bitmap decoder.
// The bitmap drives the 1024-entry multi-detect priority encoder directly,
// so N and W here must match that encoder's configuration.
package oht_bitmap_decoder_pkg;

    localparam int N = 1024;
    localparam int W = 10;

    typedef logic [N-1:0] oht_mask_t;

endpackage

// File: rtl/oht_bitmap_decoder_bin_to_oht_decoder.sv
// Binary index to one-hot mask decoder.
// Purely combinational; the mask is all-zero when enable is low so that a
// disabled request can be OR-ed / AND-ed into the bitmap with no effect.
module bin_to_oht_decoder #(
    parameter int N = oht_bitmap_decoder_pkg::N,
    parameter int W = oht_bitmap_decoder_pkg::W
) (
    input  logic         enable,
    input  logic [W-1:0] index,
    output logic [N-1:0] mask
);

    import oht_bitmap_decoder_pkg::*;

    // Raise exactly the indexed bit when enabled, nothing otherwise.
    always_comb begin
        mask = '0;
        if (enable) begin
            mask[index] = 1'b1;
        end
    end

endmodule

// File: rtl/oht_bitmap_decoder.sv
// Occupancy bitmap with set/clear index commands.
// Stage 1 registers the request and its one-hot decodes; stage 2 applies
// clr_all, then clear, then set, to the registered bitmap, and keeps an
// incremental population count, full/empty flags and duplicate/miss
// detection. Because stage 2 reads the bitmap it writes, back-to-back
// requests to the same index see each other without any forwarding.
module oht_bitmap_decoder #(
    parameter int N = oht_bitmap_decoder_pkg::N,
    parameter int W = oht_bitmap_decoder_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         set_vld,
    input  logic [W-1:0] set_bin,
    input  logic         clr_vld,
    input  logic [W-1:0] clr_bin,
    input  logic         clr_all,
    output logic [N-1:0] oht,
    output logic [W:0]   count,
    output logic         empty,
    output logic         full,
    output logic         set_dup,
    output logic         clr_miss,
    output logic         err_sticky
);

    import oht_bitmap_decoder_pkg::*;

    localparam logic [W:0] COUNT_FULL = (W+1)'(N);

    logic [N-1:0] set_mask;
    logic [N-1:0] clr_mask;

    logic         s1_set_vld;
    logic         s1_clr_vld;
    logic         s1_clr_all;
    logic [N-1:0] s1_set_mask;
    logic [N-1:0] s1_clr_mask;

    logic [N-1:0] base_vec;
    logic [N-1:0] cleared_vec;
    logic [N-1:0] oht_next;
    logic         set_dup_next;
    logic         clr_miss_next;
    logic         set_hit;
    logic         clr_hit;
    logic [W:0]   count_base;
    logic [W:0]   count_next;
    logic         err_sticky_next;

    bin_to_oht_decoder #(.N(N), .W(W)) u_set_decoder (
        .enable (set_vld),
        .index  (set_bin),
        .mask   (set_mask)
    );

    bin_to_oht_decoder #(.N(N), .W(W)) u_clr_decoder (
        .enable (clr_vld),
        .index  (clr_bin),
        .mask   (clr_mask)
    );

    // Stage 1: capture the request and its decoded masks; reset drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_set_vld  <= 1'b0;
            s1_clr_vld  <= 1'b0;
            s1_clr_all  <= 1'b0;
            s1_set_mask <= '0;
            s1_clr_mask <= '0;
        end else begin
            s1_set_vld  <= set_vld;
            s1_clr_vld  <= clr_vld;
            s1_clr_all  <= clr_all;
            s1_set_mask <= set_mask;
            s1_clr_mask <= clr_mask;
        end
    end

    // Stage 2 next-state: clr_all, then clear, then set; detection against the base.
    always_comb begin
        base_vec        = s1_clr_all ? '0 : oht;
        cleared_vec     = base_vec & ~s1_clr_mask;
        oht_next        = cleared_vec | s1_set_mask;
        clr_miss_next   = s1_clr_vld & ~(|(base_vec & s1_clr_mask));
        set_dup_next    = s1_set_vld & (|(cleared_vec & s1_set_mask));
        clr_hit         = s1_clr_vld & ~clr_miss_next;
        set_hit         = s1_set_vld & ~set_dup_next;
        count_base      = s1_clr_all ? '0 : count;
        count_next      = count_base - {{W{1'b0}}, clr_hit} + {{W{1'b0}}, set_hit};
        err_sticky_next = (s1_clr_all ? 1'b0 : err_sticky) | set_dup_next | clr_miss_next;
    end

    // Stage 2 registers: bitmap, count, flags and error pulses all update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            oht        <= '0;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            set_dup    <= 1'b0;
            clr_miss   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            oht        <= oht_next;
            count      <= count_next;
            empty      <= (count_next == '0);
            full       <= (count_next == COUNT_FULL);
            set_dup    <= set_dup_next;
            clr_miss   <= clr_miss_next;
            err_sticky <= err_sticky_next;
        end
    end

endmodule
